// File: rtl/puf_crp_sequencer.sv
// Challenge/response sequencer for an arbiter PUF: LFSR challenges, launch pulse,
// majority vote over repeated evaluations, packed response word with valid/ready.
module puf_crp_sequencer #(
    parameter int                  C_LENGTH  = 8,
    parameter logic [C_LENGTH-1:0] TAPS      = 8'hB8,
    parameter int                  N_VOTES   = 7,
    parameter int                  SETTLE    = 4,
    parameter int                  RESP_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [C_LENGTH-1:0]  seed,
    output logic                 busy,
    output logic [C_LENGTH-1:0]  ochallenge,
    output logic                 opulse,
    input  logic                 iresponse,
    output logic [RESP_BITS-1:0] resp_data,
    output logic                 resp_valid,
    input  logic                 resp_ready
);

    localparam int PW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int BW = $clog2(RESP_BITS + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_RISE   = 3'd2;
    localparam logic [2:0] S_SAMPLE = 3'd3;
    localparam logic [2:0] S_FALL   = 3'd4;
    localparam logic [2:0] S_OUT    = 3'd5;

    logic [2:0]           state;
    logic [PW-1:0]        phase_cnt;
    logic [3:0]           ones_cnt;
    logic [3:0]           vote_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [C_LENGTH-1:0]  lfsr;
    logic [RESP_BITS-1:0] resp_shift;
    logic                 sync_q1;
    logic                 sync_out;

    logic [C_LENGTH-1:0]  lfsr_next;
    logic [C_LENGTH-1:0]  seed_eff;
    logic [RESP_BITS-1:0] shift_next;
    logic                 phase_done;
    logic                 voted;

    // An all-zero seed would lock the LFSR, so it is promoted to 1.
    assign seed_eff   = (seed == '0) ? C_LENGTH'(1) : seed;
    assign lfsr_next  = {lfsr[C_LENGTH-2:0], ^(lfsr & TAPS)};
    assign phase_done = (phase_cnt == PW'(SETTLE - 1));
    assign voted      = (ones_cnt > 4'(N_VOTES / 2));
    assign shift_next = {resp_shift[RESP_BITS-2:0], voted};
    assign busy       = (state != S_IDLE);

    // NOTE: every register here uses non-blocking assignment so all of them
    // see pre-edge values; blocking would make results depend on statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            phase_cnt  <= '0;
            ones_cnt   <= '0;
            vote_cnt   <= '0;
            bit_cnt    <= '0;
            lfsr       <= '0;
            resp_shift <= '0;
            sync_q1    <= 1'b0;
            sync_out   <= 1'b0;
            ochallenge <= '0;
            opulse     <= 1'b0;
            resp_data  <= '0;
            resp_valid <= 1'b0;
        end else begin
            sync_q1  <= iresponse;
            sync_out <= sync_q1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        lfsr       <= seed_eff;
                        ochallenge <= seed_eff;
                        bit_cnt    <= '0;
                        resp_shift <= '0;
                        phase_cnt  <= '0;
                        state      <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    ones_cnt <= '0;
                    vote_cnt <= '0;
                    if (phase_done) begin
                        phase_cnt <= '0;
                        opulse    <= 1'b1;
                        state     <= S_RISE;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                S_RISE: begin
                    if (phase_done) begin
                        phase_cnt <= '0;
                        state     <= S_SAMPLE;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                // Two cycles so the synchronizer output reflects the settled arbiter.
                S_SAMPLE: begin
                    if (phase_cnt != '0) begin
                        ones_cnt  <= ones_cnt + {3'b000, sync_out};
                        vote_cnt  <= vote_cnt + 4'd1;
                        phase_cnt <= '0;
                        opulse    <= 1'b0;
                        state     <= S_FALL;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                S_FALL: begin
                    if (phase_done) begin
                        phase_cnt <= '0;
                        if (vote_cnt < 4'(N_VOTES)) begin
                            opulse <= 1'b1;
                            state  <= S_RISE;
                        end else begin
                            resp_shift <= shift_next;
                            bit_cnt    <= bit_cnt + 1'b1;
                            lfsr       <= lfsr_next;
                            if (bit_cnt == BW'(RESP_BITS - 1)) begin
                                resp_data  <= shift_next;
                                resp_valid <= 1'b1;
                                state      <= S_OUT;
                            end else begin
                                ochallenge <= lfsr_next;
                                state      <= S_SETUP;
                            end
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                S_OUT: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_crp_sequencer.sv
// Randomized scoreboard bench for puf_crp_sequencer: a reference model queues
// expected challenges and words; a negedge monitor drives the PUF and compares.
module tb_puf_crp_sequencer;

    localparam int         RB     = 8;
    localparam int         NV     = 7;
    localparam int         ST     = 4;
    localparam logic [7:0] TAPS_M = 8'hB8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] seed;
    logic       busy;
    logic [7:0] ochallenge;
    logic       opulse;
    logic       iresponse;
    logic [7:0] resp_data;
    logic       resp_valid;
    logic       resp_ready;

    puf_crp_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .seed       (seed),
        .busy       (busy),
        .ochallenge (ochallenge),
        .opulse     (opulse),
        .iresponse  (iresponse),
        .resp_data  (resp_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0] exp_chal_q[$];
    logic [7:0] exp_word_q[$];
    bit         eval_plan[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] lfsr_adv(input logic [7:0] c);
        bit fb;
        fb = ($countones(c & TAPS_M) % 2) == 1;
        return {c[6:0], fb};
    endfunction

    // Model: challenge list, per-evaluation PUF answers, and the voted word.
    task automatic prepare(input logic [7:0] s, input int mode);
        logic [7:0] c;
        logic [7:0] word;
        int         ones;
        bit         b;
        c    = (s == 8'h00) ? 8'h01 : s;
        word = 8'h00;
        for (int i = 0; i < RB; i++) begin
            exp_chal_q.push_back(c);
            ones = 0;
            for (int v = 0; v < NV; v++) begin
                case (mode)
                    0:       b = 1'b1;
                    1:       b = 1'b0;
                    2:       b = (i == 0 && v < 4) || (i == 1 && v < 3);
                    default: b = ($urandom_range(0, 1) == 1);
                endcase
                eval_plan.push_back(b);
                ones += int'(b);
            end
            word = {word[6:0], ones > NV / 2};
            c    = lfsr_adv(c);
        end
        exp_word_q.push_back(word);
    endtask

    // Monitor: drives the PUF answer per pulse and checks pulse shape, challenges, words.
    logic       prev_pulse;
    int         high_len, low_len, pulses_this;
    logic [7:0] cur_chal, rise_chal;

    always @(negedge clk) begin
        if (rst) begin
            prev_pulse  = 1'b0;
            high_len    = 0;
            low_len     = 0;
            pulses_this = NV;
            cur_chal    = 8'h00;
        end else begin
            if (opulse && !prev_pulse) begin
                if (pulses_this == NV) begin
                    check("chal_queue_nonempty", 32'(exp_chal_q.size() > 0), 1);
                    if (exp_chal_q.size() > 0) cur_chal = exp_chal_q.pop_front();
                    pulses_this = 0;
                end else begin
                    check("low_len", low_len, ST);
                end
                check("challenge", ochallenge, cur_chal);
                pulses_this++;
                high_len  = 1;
                rise_chal = ochallenge;
                iresponse = (eval_plan.size() > 0) ? eval_plan.pop_front() : 1'b0;
            end else if (opulse) begin
                high_len++;
            end else if (prev_pulse) begin
                check("high_len", high_len, ST + 2);
                check("chal_stable", ochallenge, rise_chal);
                low_len = 1;
            end else begin
                low_len++;
            end
            if (resp_valid && resp_ready) begin
                check("word_queue_nonempty", 32'(exp_word_q.size() > 0), 1);
                if (exp_word_q.size() > 0) check("resp_data", resp_data, exp_word_q.pop_front());
            end
            prev_pulse = opulse;
        end
    end

    task automatic run_word(input logic [7:0] s, input bit hold);
        int         cyc;
        logic [7:0] held;
        bit         stable;
        @(posedge clk);
        #1;
        resp_ready = !hold;
        seed       = s;
        start      = 1'b1;
        cyc        = 0;
        while (cyc < 3000) begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == 1) begin
                start = 1'b0;
                seed  = 8'($urandom);
            end
            if (cyc == 150) start = 1'b1;
            if (cyc == 151) start = 1'b0;
            @(negedge clk);
            if (resp_valid) break;
        end
        check("valid_latency", cyc, 593);
        if (hold) begin
            held   = resp_data;
            stable = 1'b1;
            repeat (50) begin
                @(negedge clk);
                if (!resp_valid || resp_data !== held || !busy) stable = 1'b0;
            end
            check("hold_stable", 32'(stable), 1);
            @(posedge clk);
            #1 resp_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        check("valid_after_xfer", 32'(resp_valid), 0);
        check("busy_after_xfer", 32'(busy), 0);
        check("chal_q_drained", exp_chal_q.size(), 0);
        check("plan_drained", eval_plan.size(), 0);
        resp_ready = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int w;
        rst        = 1'b1;
        start      = 1'b0;
        seed       = 8'h00;
        iresponse  = 1'b0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_opulse", 32'(opulse), 0);
        check("rst_challenge", ochallenge, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        prepare(8'h01, 0); run_word(8'h01, 1'b0);
        prepare(8'h5A, 1); run_word(8'h5A, 1'b0);
        prepare(8'h3C, 2); run_word(8'h3C, 1'b0);
        prepare(8'h00, 0); run_word(8'h00, 1'b0);
        prepare(8'hC3, 3); run_word(8'hC3, 1'b1);
        for (int k = 0; k < 3; k++) begin
            logic [7:0] rs;
            rs = 8'($urandom);
            prepare(rs, 3);
            run_word(rs, 1'b0);
        end

        // Reset in the middle of a launch pulse.
        prepare(8'h01, 0);
        @(posedge clk);
        #1 seed = 8'h01; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        w = 0;
        while (!opulse && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("pulse_found", 32'(opulse), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_opulse", 32'(opulse), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_valid", 32'(resp_valid), 0);
        check("midrst_data", resp_data, 0);
        check("midrst_challenge", ochallenge, 0);
        exp_chal_q.delete();
        exp_word_q.delete();
        eval_plan.delete();
        iresponse = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        prepare(8'h01, 0); run_word(8'h01, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
